sram_1r1w_pipe_model: RTL and testbench



---
 rtl/sram_1r1w_pipe_model.sv | 125 ++++++++++++
 tb/tb_sram_1r1w_pipe_model.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_pipe_model.sv
// Behavioural 1R1W SRAM with per-lane write mask, READ_LATENCY-deep read pipeline,
// selectable same-address collision policy and a saturating collision counter.
module sram_1r1w_pipe_model #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 7,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS_MODE  = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   csb0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_valid,
    output logic [CNT_WIDTH-1:0]   collision_cnt
);

    localparam int LW    = DATA_WIDTH / WMASK_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fwd_merge(input logic [DATA_WIDTH-1:0] old_d,
                                                        input logic [DATA_WIDTH-1:0] new_d,
                                                        input logic [DATA_WIDTH-1:0] m);
        return (new_d & m) | (old_d & ~m);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] x_merge(input logic [DATA_WIDTH-1:0] old_d,
                                                      input logic [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] r;
        for (int b = 0; b < DATA_WIDTH; b++)
            r[b] = m[b] ? 1'bx : old_d[b];
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_p [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_vld_p;

    logic [DATA_WIDTH-1:0] w_lane_mask;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_rd;
    logic                  w_coll;

    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < WMASK_WIDTH; i++)
            w_lane_mask[i*LW +: LW] = {LW{wmask0[i]}};
    end

    assign w_rd     = ~csb1;
    assign w_coll   = ~csb0 & ~csb1 & (addr0 == addr1) & (|wmask0);
    // Array value before this edge's write: the read sees pre-write data.
    assign w_rd_old = r_mem[addr1];

    always_comb begin
        w_rd_data = w_rd_old;
        if (w_coll) begin
            if (BYPASS_MODE == 1)
                w_rd_data = fwd_merge(w_rd_old, din0, w_lane_mask);
            else if (BYPASS_MODE == 2)
                w_rd_data = x_merge(w_rd_old, w_lane_mask);
        end
    end

    // Array write; the array is never cleared and ignores edges during reset
    always_ff @(posedge clk) begin
        if (rstb && !csb0) begin
            for (int i = 0; i < WMASK_WIDTH; i++)
                if (wmask0[i])
                    r_mem[addr0][i*LW +: LW] <= din0[i*LW +: LW];
        end
    end

    // Stage p0 captures at the sample edge; stage p(k) one edge later each
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_rd;
            for (int k = 1; k < READ_LATENCY; k++)
                r_vld_p[k] <= r_vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        r_data_p[0] <= w_rd_data;
        for (int k = 1; k < READ_LATENCY; k++)
            r_data_p[k] <= r_data_p[k-1];
    end

    // Output stage: dout1 holds its last result until a new one completes
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            dout1         <= '0;
            dout1_valid   <= 1'b0;
            collision_cnt <= '0;
        end else begin
            dout1_valid <= r_vld_p[READ_LATENCY-1];
            if (r_vld_p[READ_LATENCY-1])
                dout1 <= r_data_p[READ_LATENCY-1];
            if (w_coll)
                collision_cnt <= sat_inc(collision_cnt);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstb && w_coll)
            $display("sram_1r1w_pipe_model warning: collision t=%0t addr0=%h policy=%0d",
                     $time, addr0, BYPASS_MODE);
    end
`endif

endmodule

// File: tb/tb_sram_1r1w_pipe_model.sv
// Random + directed bench: three DUT configurations share stimulus and are checked
// against a time-scheduled memory reference model.
module tb_sram_1r1w_pipe_model;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        csb0 = 1'b1;
    logic [6:0]  addr0 = '0;
    logic [31:0] din0 = '0;
    logic [3:0]  wmask0 = '0;
    logic        csb1 = 1'b1;
    logic [6:0]  addr1 = '0;

    logic [31:0] o_dout [3];
    logic        o_vld  [3];
    logic [7:0]  o_cnt  [3];
    logic [3:0]  cnt4_0, cnt4_1;

    assign o_cnt[0] = {4'b0, cnt4_0};
    assign o_cnt[1] = {4'b0, cnt4_1};

    always #5 clk = ~clk;

    sram_1r1w_pipe_model #(.READ_LATENCY(1), .BYPASS_MODE(0), .CNT_WIDTH(4)) u_m0 (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(o_dout[0]), .dout1_valid(o_vld[0]),
        .collision_cnt(cnt4_0));

    sram_1r1w_pipe_model #(.READ_LATENCY(3), .BYPASS_MODE(1), .CNT_WIDTH(4)) u_m1 (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(o_dout[1]), .dout1_valid(o_vld[1]),
        .collision_cnt(cnt4_1));

    sram_1r1w_pipe_model #(.READ_LATENCY(2), .BYPASS_MODE(2), .CNT_WIDTH(8)) u_m2 (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(o_dout[2]), .dout1_valid(o_vld[2]),
        .collision_cnt(o_cnt[2]));

    int rl_of   [3] = '{1, 3, 2};
    int mode_of [3] = '{0, 1, 2};
    int cmax_of [3] = '{15, 15, 255};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: plain memory plus a schedule of results keyed by completion cycle
    logic [31:0] m_mem [128];
    logic        sch_v [3][8];
    logic [31:0] sch_d [3][8];
    logic [31:0] sch_k [3][8];
    logic [31:0] m_dout [3];
    logic [31:0] m_kn   [3];
    int          m_cnt  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 8; s++) sch_v[k][s] = 1'b0;
            m_dout[k] = '0;
            m_kn[k]   = '1;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] p, lm, v, kn;
        logic        coll;
        int          slot;
        cyc++;
        if (rstb) begin
            p    = m_mem[addr1];
            lm   = expand(wmask0);
            coll = !csb0 && !csb1 && (addr0 == addr1) && (wmask0 != 4'h0);
            for (int k = 0; k < 3; k++) begin
                if (!csb1) begin
                    v  = p;
                    kn = '1;
                    if (coll && mode_of[k] == 1) v = (din0 & lm) | (p & ~lm);
                    if (coll && mode_of[k] == 2) kn = ~lm;
                    slot = (cyc + rl_of[k]) % 8;
                    sch_v[k][slot] = 1'b1;
                    sch_d[k][slot] = v;
                    sch_k[k][slot] = kn;
                end
                if (coll && m_cnt[k] < cmax_of[k]) m_cnt[k]++;
            end
            if (!csb0) m_mem[addr0] = (din0 & lm) | (m_mem[addr0] & ~lm);
        end
    endtask

    task automatic check_outputs();
        int slot;
        slot = cyc % 8;
        for (int k = 0; k < 3; k++) begin
            if (sch_v[k][slot]) begin
                chk($sformatf("valid%0d", k), {31'b0, o_vld[k]}, 32'd1);
                chk($sformatf("dout%0d", k), o_dout[k] & sch_k[k][slot],
                    sch_d[k][slot] & sch_k[k][slot]);
                m_dout[k] = sch_d[k][slot];
                m_kn[k]   = sch_k[k][slot];
                sch_v[k][slot] = 1'b0;
            end else begin
                chk($sformatf("idle_valid%0d", k), {31'b0, o_vld[k]}, 32'd0);
                chk($sformatf("hold_dout%0d", k), o_dout[k] & m_kn[k], m_dout[k] & m_kn[k]);
            end
            chk($sformatf("cnt%0d", k), {24'b0, o_cnt[k]}, m_cnt[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic c0, input logic [6:0] a0, input logic [31:0] d0,
                         input logic [3:0] wm, input logic c1, input logic [6:0] a1);
        csb0 = c0; addr0 = a0; din0 = d0; wmask0 = wm; csb1 = c1; addr1 = a1;
    endtask

    task automatic idle(input int n);
        drive(1'b1, '0, '0, '0, 1'b1, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called just after a sampling point; reset edges fall between clock edges
    task automatic do_reset();
        #2 rstb = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), {31'b0, o_vld[k]}, 32'd0);
            chk($sformatf("rst_dout%0d", k), o_dout[k], 32'd0);
            chk($sformatf("rst_cnt%0d", k), {24'b0, o_cnt[k]}, 32'd0);
        end
        tick();
        tick();
        #2 rstb = 1'b1;
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        #2 rstb = 1'b1;

        // Fill the array so every later read has defined contents
        for (int a = 0; a < 128; a++) begin
            drive(1'b0, 7'(a), $urandom, 4'hF, 1'b1, '0);
            tick();
        end

        // Full write then read on the next cycle; latency-1 result one edge later
        drive(1'b0, 7'h05, 32'hDEADBEEF, 4'hF, 1'b1, '0);
        tick();
        drive(1'b1, '0, '0, '0, 1'b0, 7'h05);
        tick();
        idle(1);
        chk("rd_basic_valid", {31'b0, o_vld[0]}, 32'd1);
        chk("rd_basic_data", o_dout[0], 32'hDEADBEEF);
        idle(4);

        // Lane-masked write
        drive(1'b0, 7'h10, 32'h11223344, 4'hF, 1'b1, '0);
        tick();
        drive(1'b0, 7'h10, 32'hAABBCCDD, 4'h5, 1'b1, '0);
        tick();
        drive(1'b1, '0, '0, '0, 1'b0, 7'h10);
        tick();
        idle(1);
        chk("masked_data", o_dout[0], 32'h11BB33DD);
        idle(4);

        // Same-address collision under all three policies
        drive(1'b0, 7'h20, 32'h0, 4'hF, 1'b1, '0);
        tick();
        drive(1'b0, 7'h20, 32'hFFFFFFFF, 4'h3, 1'b0, 7'h20);
        tick();
        idle(3);
        chk("coll_mode0", o_dout[0], 32'h00000000);
        chk("coll_mode1", o_dout[1], 32'h0000FFFF);
        chk("coll_mode2_hi", o_dout[2] & 32'hFFFF0000, 32'h0);
        chk("coll_cnt0", {24'b0, o_cnt[0]}, 32'd1);
        chk("coll_cnt2", {24'b0, o_cnt[2]}, 32'd1);
        idle(3);

        // Back-to-back reads, then the same with reset landing after the second one
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, '0, '0, '0, 1'b0, 7'(i));
            tick();
        end
        idle(5);
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, '0, '0, '0, 1'b0, 7'(i));
            tick();
        end
        drive(1'b1, '0, '0, '0, 1'b0, 7'h03);
        do_reset();
        idle(5);

        // Counter saturation; a zero-mask same-address cycle is not a collision
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 7'h40, $urandom, 4'(1 + $urandom_range(0, 14)), 1'b0, 7'h40);
            tick();
        end
        drive(1'b0, 7'h40, $urandom, 4'h0, 1'b0, 7'h40);
        tick();
        idle(3);
        chk("sat_cnt0", {24'b0, o_cnt[0]}, 32'd15);
        chk("sat_cnt1", {24'b0, o_cnt[1]}, 32'd15);
        chk("sat_cnt2", {24'b0, o_cnt[2]}, 32'd20);

        // Random traffic over a narrow address window to provoke collisions
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0),
                  7'($urandom_range(0, 7)));
            tick();
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
